// File: rtl/bios_dl_pkg.sv
// Shared constants for the BIOS/program RAM download arbiter.
package bios_dl_pkg;

  // hps_io ioctl interface widths
  localparam int IOCTL_AW       = 25;
  localparam int IOCTL_DW       = 8;
  localparam int IOCTL_IDX_W    = 8;

  // ioctl_index values below this land in the BIOS RAM
  localparam int DL_IDX_MAX_DEF = 2;

  // Arbiter states (visible on dbg_state)
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CPU_ACK = 2'd1;
  localparam logic [1:0] S_DL      = 2'd2;
  localparam logic [1:0] S_TAIL    = 2'd3;

endpackage

// File: rtl/bios_dl_arbiter.sv
// Single-port BIOS RAM arbiter: HPS ioctl download owns the RAM while active,
// the core CPU gets it otherwise. Core reset is held through the download and
// for RST_TAIL cycles afterwards.
//
// Handshakes: ioctl_wr is a one-cycle strobe accepted only when ioctl_wait=0;
// cpu_req is a level, held by the CPU until cpu_ack pulses for one cycle,
// with cpu_rdata valid only in that cycle.
module bios_dl_arbiter
  import bios_dl_pkg::*;
#(
  parameter int AW         = 14,
  parameter int DL_IDX_MAX = DL_IDX_MAX_DEF,
  parameter int RST_TAIL   = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic [IOCTL_IDX_W-1:0] ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [IOCTL_AW-1:0]    ioctl_addr,
  input  logic [IOCTL_DW-1:0]    ioctl_dout,
  output logic                   ioctl_wait,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [7:0]             cpu_wdata,
  output logic                   cpu_ack,
  output logic [7:0]             cpu_rdata,
  output logic [AW-1:0]          ram_addr,
  output logic                   ram_we,
  output logic [7:0]             ram_d,
  input  logic [7:0]             ram_q,
  output logic                   core_reset,
  output logic [AW:0]            dl_bytes,
  output logic                   oob_err,
  output logic [1:0]             dbg_state
);

  localparam int TW = $clog2(RST_TAIL + 1);
  localparam logic [IOCTL_IDX_W-1:0] IDX_LIM = IOCTL_IDX_W'(DL_IDX_MAX);
  localparam logic [AW:0] BYTES_MAX = '1;
  localparam logic [AW:0] BYTES_ONE = {{AW{1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tail_q, tail_d;
  logic          buf_v_q, buf_v_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]    buf_data_q, buf_data_d;
  logic [AW:0]   dl_bytes_q, dl_bytes_d;
  logic          oob_q, oob_d;
  logic          core_reset_q, core_reset_d;

  logic dl_act;
  logic addr_oob;

  assign dl_act   = ioctl_download & (ioctl_index < IDX_LIM);
  assign addr_oob = |ioctl_addr[IOCTL_AW-1:AW];

  // Next-state, buffer, counters and RAM port steering
  always_comb begin
    state_d    = state_q;
    tail_d     = tail_q;
    buf_v_d    = buf_v_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    dl_bytes_d = dl_bytes_q;
    oob_d      = oob_q;
    ram_addr   = cpu_addr;
    ram_d      = cpu_wdata;
    ram_we     = 1'b0;
    cpu_ack    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A download starting this cycle wins; the CPU request waits.
        if (dl_act) begin
          state_d = S_DL;
        end else if (cpu_req) begin
          ram_we  = cpu_we;
          state_d = S_CPU_ACK;
        end
      end
      S_CPU_ACK: begin
        cpu_ack = 1'b1;
        state_d = dl_act ? S_DL : S_IDLE;
      end
      S_DL: begin
        ram_addr = buf_addr_q;
        ram_d    = buf_data_q;
        ram_we   = buf_v_q;
        if (buf_v_q) begin
          buf_v_d = 1'b0;
          if (dl_bytes_q != BYTES_MAX) dl_bytes_d = dl_bytes_q + BYTES_ONE;
        end
        if (dl_act && ioctl_wr) begin
          // Out-of-range or colliding writes are dropped and flagged.
          if (buf_v_q || addr_oob) begin
            oob_d = 1'b1;
          end else begin
            buf_v_d    = 1'b1;
            buf_addr_d = ioctl_addr[AW-1:0];
            buf_data_d = ioctl_dout;
          end
        end
        if (!dl_act && !buf_v_q) begin
          state_d = S_TAIL;
          tail_d  = TW'(RST_TAIL);
        end
      end
      default: begin  // S_TAIL
        if (dl_act) begin
          state_d = S_DL;
        end else if (tail_q <= TW'(1)) begin
          state_d = S_IDLE;
          tail_d  = '0;
        end else begin
          tail_d = tail_q - TW'(1);
        end
      end
    endcase
    // Every new download starts with fresh statistics.
    if (state_q != S_DL && state_d == S_DL) begin
      dl_bytes_d = '0;
      oob_d      = 1'b0;
    end
    core_reset_d = (state_d == S_DL) || (state_d == S_TAIL);
  end

  // State and datapath registers; reset drops any buffered byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_TAIL;
      tail_q       <= TW'(RST_TAIL);
      buf_v_q      <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      dl_bytes_q   <= '0;
      oob_q        <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tail_q       <= tail_d;
      buf_v_q      <= buf_v_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      dl_bytes_q   <= dl_bytes_d;
      oob_q        <= oob_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign ioctl_wait = buf_v_q | (dl_act & (state_q != S_DL));
  assign cpu_rdata  = cpu_ack ? ram_q : 8'h00;
  assign core_reset = core_reset_q;
  assign dl_bytes   = dl_bytes_q;
  assign oob_err    = oob_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bios_dl_arbiter.sv
// Directed bench for bios_dl_arbiter with a behavioural single-port RAM.
module tb_bios_dl_arbiter;
  import bios_dl_pkg::*;

  localparam int AW = 14;
  localparam int SW = AW + 8;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index    = 8'd0;
  logic          ioctl_wr       = 1'b0;
  logic [24:0]   ioctl_addr     = '0;
  logic [7:0]    ioctl_dout     = '0;
  logic          ioctl_wait;
  logic          cpu_req   = 1'b0;
  logic          cpu_we    = 1'b0;
  logic [AW-1:0] cpu_addr  = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_d;
  logic [7:0]    ram_q;
  logic          core_reset;
  logic [AW:0]   dl_bytes;
  logic          oob_err;
  logic [1:0]    dbg_state;

  bios_dl_arbiter #(.AW(AW), .DL_IDX_MAX(2), .RST_TAIL(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
    .core_reset(core_reset), .dl_bytes(dl_bytes), .oob_err(oob_err),
    .dbg_state(dbg_state)
  );

  // Behavioural RAM, 1-cycle read latency
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every RAM write must match the next expected {addr,data}
  always begin
    @(negedge clk_sys);
    #2;
    if (reset_n && ram_we) begin
      if (exp_q.size() == 0) begin
        chk("ram_we_unexpected", {8'h0, ram_addr, ram_d}, 32'h0);
      end else begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        chk("ram_write", {10'h0, ram_addr, ram_d}, {10'h0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; ends at a negedge two cycles later.
  task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
    logic inr;
    inr = (a < 25'(1 << AW));
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (inr) exp_q.push_back({a[AW-1:0], d});
    @(negedge clk_sys);
    chk("dl_we_latency", {31'h0, ram_we}, {31'h0, inr});
    chk("dl_wait_full", {31'h0, ioctl_wait}, {31'h0, inr});
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  // Called at a negedge; returns at the negedge where cpu_ack is seen.
  task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                            input logic [7:0] wd, output logic [7:0] rd);
    logic got;
    got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    if (we) exp_q.push_back({a, wd});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin got = 1'b1; break; end
    end
    chk("cpu_ack_seen", {31'h0, got}, 32'h1);
    rd = cpu_rdata;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read_chk(input logic [AW-1:0] a, input logic [7:0] e);
    logic [7:0] rd;
    cpu_access(1'b0, a, 8'h00, rd);
    chk("cpu_rdata", {24'h0, rd}, {24'h0, e});
    @(negedge clk_sys);
  endtask

  task automatic wait_core_run();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_sys);
      if (!core_reset) begin done = 1'b0 | 1'b1; break; end
    end
    chk("tail_end", {31'h0, done}, 32'h1);
  endtask

  // Release reset at a negedge and measure the core_reset tail
  task automatic release_and_count();
    int n;
    n = 0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (core_reset) n++;
      else break;
      @(negedge clk_sys);
    end
    chk("rst_tail_len", n, 16);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd;

    // Reset values
    repeat (3) @(negedge clk_sys);
    chk("rst_core_reset", {31'h0, core_reset}, 32'h1);
    chk("rst_ioctl_wait", {31'h0, ioctl_wait}, 32'h0);
    chk("rst_cpu_ack",    {31'h0, cpu_ack}, 32'h0);
    chk("rst_ram_we",     {31'h0, ram_we}, 32'h0);
    chk("rst_dl_bytes",   {17'h0, dl_bytes}, 32'h0);
    chk("rst_oob_err",    {31'h0, oob_err}, 32'h0);
    chk("rst_state",      {30'h0, dbg_state}, {30'h0, S_TAIL});
    release_and_count();
    chk("idle_state",     {30'h0, dbg_state}, {30'h0, S_IDLE});
    chk("idle_cpu_rdata", {24'h0, cpu_rdata}, 32'h0);

    // CPU write then read back
    cpu_access(1'b1, 14'h0123, 8'h5A, rd);
    @(negedge clk_sys);
    chk("cpu_ack_pulse", {31'h0, cpu_ack}, 32'h0);
    cpu_read_chk(14'h0123, 8'h5A);

    // 256-byte download on index 0
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    #1 chk("dl_wait_idle", {31'h0, ioctl_wait}, 32'h1);
    @(negedge clk_sys);
    chk("dl_state", {30'h0, dbg_state}, {30'h0, S_DL});
    chk("dl_core_reset", {31'h0, core_reset}, 32'h1);
    chk("dl_wait_empty", {31'h0, ioctl_wait}, 32'h0);
    for (int i = 0; i < 256; i++) dl_write(25'(i), 8'(i));
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("dl_to_tail", {30'h0, dbg_state}, {30'h0, S_TAIL});
    chk("dl_bytes_256", {17'h0, dl_bytes}, 32'd256);
    chk("dl_no_oob", {31'h0, oob_err}, 32'h0);
    wait_core_run();
    cpu_read_chk(14'h0080, 8'h80);

    // CPU read in flight when a download starts
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
    @(negedge clk_sys);
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    #1;
    chk("race_cpu_ack",   {31'h0, cpu_ack}, 32'h1);
    chk("race_cpu_rdata", {24'h0, cpu_rdata}, 32'h10);
    chk("race_wait",      {31'h0, ioctl_wait}, 32'h1);
    @(negedge clk_sys);
    chk("race_state", {30'h0, dbg_state}, {30'h0, S_DL});
    for (int i = 0; i < 4; i++) begin
      chk("race_no_ack", {31'h0, cpu_ack}, 32'h0);
      @(negedge clk_sys);
    end
    cpu_req = 1'b0;

    // Out-of-range address, then top in-range address
    dl_write(25'h4000, 8'h77);
    chk("oob_flag", {31'h0, oob_err}, 32'h1);
    chk("oob_bytes", {17'h0, dl_bytes}, 32'h0);
    dl_write(25'h3FFF, 8'hC3);
    chk("oob_sticky", {31'h0, oob_err}, 32'h1);
    chk("top_bytes", {17'h0, dl_bytes}, 32'h1);
    ioctl_download = 1'b0;
    wait_core_run();

    // Back-to-back ioctl_wr: second is dropped
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("b2b_oob_clear", {31'h0, oob_err}, 32'h0);
    ioctl_wr = 1'b1; ioctl_addr = 25'h5; ioctl_dout = 8'hA5;
    exp_q.push_back({14'h5, 8'hA5});
    @(negedge clk_sys);
    chk("b2b_wait", {31'h0, ioctl_wait}, 32'h1);
    ioctl_addr = 25'h6; ioctl_dout = 8'h66;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    chk("b2b_no_we", {31'h0, ram_we}, 32'h0);
    chk("b2b_oob", {31'h0, oob_err}, 32'h1);
    chk("b2b_bytes", {17'h0, dl_bytes}, 32'h1);
    ioctl_download = 1'b0;
    wait_core_run();

    // Index 2 is not ours
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    #1 chk("idx2_wait", {31'h0, ioctl_wait}, 32'h0);
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = 25'h20; ioctl_dout = 8'hEE;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (8) @(negedge clk_sys);
    chk("idx2_core_reset", {31'h0, core_reset}, 32'h0);
    chk("idx2_state", {30'h0, dbg_state}, {30'h0, S_IDLE});
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    cpu_read_chk(14'h0020, 8'h20);
    cpu_read_chk(14'h3FFF, 8'hC3);
    cpu_read_chk(14'h0005, 8'hA5);
    cpu_read_chk(14'h0006, 8'h06);

    // reset_n asserted with a byte buffered
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = 25'h30; ioctl_dout = 8'h99;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    #1 chk("abort_buffered", {31'h0, ram_we}, 32'h1);
    reset_n = 1'b0;
    #0.5;
    chk("abort_we", {31'h0, ram_we}, 32'h0);
    chk("abort_core_reset", {31'h0, core_reset}, 32'h1);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    release_and_count();
    cpu_read_chk(14'h0030, 8'h30);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
